// File: rtl/rj_coeff_loader.sv
// Serial-to-parallel coefficient loader for the right-channel coefficient memory.
// Deserialises MSB-first framed words, writes them to consecutive rows, and can zero-sweep all rows first.
//  state      | meaning
//  IDLE       | waiting for start
//  ZSET       | zero-sweep setup cycle, Input=0
//  ZSTB       | zero-sweep write strobe
//  WAIT_FRAME | waiting for Frame to mark a word MSB
//  SHIFT      | shifting the remaining word bits
//  WSET       | assembled word presented, setup cycle
//  WSTB       | word write strobe
//  DONE       | load_done pulse, row returns to 0
module rj_coeff_loader #(
   parameter int WIDTH  = 16,
   parameter int NWORDS = 16,
   parameter int ROWW   = 4
) (
   input  logic             Sclk,
   input  logic             Reset,
   input  logic             start,
   input  logic             zero_first,
   input  logic             Frame,
   input  logic             Sdata,
   output logic [ROWW-1:0]  row,
   output logic [WIDTH-1:0] Input,
   output logic             rj_status,
   output logic             clear,
   output logic             busy,
   output logic             load_done
);

   typedef enum logic [2:0] {
      IDLE, ZSET, ZSTB, WAIT_FRAME, SHIFT, WSET, WSTB, DONE
   } state_t;

   localparam int              CW       = $clog2(WIDTH);
   localparam logic [ROWW-1:0] LAST_ROW = ROWW'(NWORDS - 1);
   localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

   state_t           state, state_nxt;
   logic [WIDTH-2:0] sreg;
   logic [CW-1:0]    bcnt;
   logic             row_adv;
   logic             last_row;
   logic             strobe_nxt, clear_nxt, busy_nxt, done_nxt;

   assign last_row = (row == LAST_ROW);

   always_ff @(posedge Sclk or posedge Reset) begin
      if (Reset) begin
         state     <= IDLE;
         rj_status <= 1'b0;
         clear     <= 1'b0;
         busy      <= 1'b0;
         load_done <= 1'b0;
         row       <= '0;
         Input     <= '0;
         sreg      <= '0;
         bcnt      <= '0;
         row_adv   <= 1'b0;
      end else begin
         state     <= state_nxt;
         rj_status <= strobe_nxt;
         clear     <= clear_nxt;
         busy      <= busy_nxt;
         load_done <= done_nxt;
         if (state_nxt == ZSET)
            Input <= '0;
         case (state)
            IDLE: if (start) begin
               row     <= '0;
               row_adv <= 1'b0;
            end
            ZSTB: row <= last_row ? '0 : row + 1'b1;
            WAIT_FRAME: begin
               // Row advance is deferred to here so row stays valid one cycle past the strobe
               if (row_adv) begin
                  row     <= row + 1'b1;
                  row_adv <= 1'b0;
               end
               if (Frame) begin
                  sreg <= {{(WIDTH-2){1'b0}}, Sdata};
                  bcnt <= CW'(1);
               end
            end
            SHIFT: begin
               sreg <= {sreg[WIDTH-3:0], Sdata};
               bcnt <= bcnt + 1'b1;
               if (bcnt == LAST_BIT) begin
                  Input <= {sreg, Sdata};
                  bcnt  <= '0;
               end
            end
            WSTB: if (!last_row) row_adv <= 1'b1;
            DONE: begin
               row     <= '0;
               row_adv <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:       if (start) state_nxt = zero_first ? ZSET : WAIT_FRAME;
         ZSET:       state_nxt = ZSTB;
         ZSTB:       state_nxt = last_row ? WAIT_FRAME : ZSET;
         WAIT_FRAME: if (Frame) state_nxt = SHIFT;
         SHIFT:      if (bcnt == LAST_BIT) state_nxt = WSET;
         WSET:       state_nxt = WSTB;
         WSTB:       state_nxt = last_row ? DONE : WAIT_FRAME;
         DONE:       state_nxt = IDLE;
         default:    state_nxt = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so each comes straight from a flop
   always_comb begin
      strobe_nxt = (state_nxt == ZSTB) || (state_nxt == WSTB);
      clear_nxt  = (state_nxt == ZSET) || (state_nxt == ZSTB);
      busy_nxt   = (state_nxt != IDLE);
      done_nxt   = (state_nxt == DONE);
   end

endmodule
